// File: rtl/fesvr_harness_pkg.sv
// Shared address map, decode type and request/response structs for the
// fesvr harness memory block.
package fesvr_harness_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_WORDS  = 4096;

    localparam logic [ADDR_WIDTH-1:0] MEM_BASE      = 32'h8000_0000;
    localparam logic [ADDR_WIDTH-1:0] TOHOST_ADDR   = 32'h0000_1000;
    localparam logic [ADDR_WIDTH-1:0] FROMHOST_ADDR = 32'h0000_1008;

    typedef enum logic [1:0] {
        DEC_RAM      = 2'd0,
        DEC_TOHOST   = 2'd1,
        DEC_FROMHOST = 2'd2,
        DEC_NONE     = 2'd3
    } decode_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } mem_rsp_t;

    // Replace only the bytes whose strobe is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fesvr_harness_mem_sram.sv
// Single-port byte-strobed RAM with one cycle of read latency; the array is
// deliberately never reset so a loaded program survives harness resets.
module harness_sram #(
    parameter int DataWidth = 64,
    parameter int Words     = 4096,
    parameter int IdxWidth  = $clog2(Words)
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [IdxWidth-1:0]    idx_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] strb_i,
    output logic [DataWidth-1:0]   rdata_o
);

    logic [DataWidth-1:0] mem_r [Words];
    logic [DataWidth-1:0] rdata_r;

    // Array write and registered read; the read holds its value between reads.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DataWidth/8; b++) begin
                    if (strb_i[b]) begin
                        mem_r[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_r <= mem_r[idx_i];
            end
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/fesvr_harness_mem.sv
// Harness memory for the cluster data port plus tohost/fromhost mailboxes
// shared with the fesvr host model; the host always wins the single port.
module fesvr_harness_mem
    import fesvr_harness_pkg::*;
#(
    parameter int                    AddrWidth    = ADDR_WIDTH,
    parameter int                    DataWidth    = DATA_WIDTH,
    parameter logic [AddrWidth-1:0]  MemBase      = MEM_BASE,
    parameter int                    MemWords     = MEM_WORDS,
    parameter logic [AddrWidth-1:0]  TohostAddr   = TOHOST_ADDR,
    parameter logic [AddrWidth-1:0]  FromhostAddr = FROMHOST_ADDR
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_we_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    output logic                   rsp_valid_o,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic                   host_req_i,
    input  logic                   host_we_i,
    input  logic [AddrWidth-1:0]   host_addr_i,
    input  logic [DataWidth-1:0]   host_wdata_i,
    output logic                   host_rvalid_o,
    output logic [DataWidth-1:0]   host_rdata_o,
    output logic                   exit_valid_o,
    output logic [31:0]            exit_code_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int OffBits   = $clog2(StrbWidth);
    localparam int IdxWidth  = $clog2(MemWords);
    localparam logic [AddrWidth-1:0] MemLimit = MemBase + AddrWidth'(MemWords * StrbWidth);

    function automatic decode_e decode(input logic [AddrWidth-1:0] addr);
        decode_e d;
        if ((addr >= MemBase) && (addr < MemLimit)) begin
            d = DEC_RAM;
        end else if (addr[AddrWidth-1:OffBits] == TohostAddr[AddrWidth-1:OffBits]) begin
            d = DEC_TOHOST;
        end else if (addr[AddrWidth-1:OffBits] == FromhostAddr[AddrWidth-1:OffBits]) begin
            d = DEC_FROMHOST;
        end else begin
            d = DEC_NONE;
        end
        return d;
    endfunction

    decode_e              cl_dec_s;
    decode_e              host_dec_s;
    logic                 cl_fire_s;
    mem_req_t             sram_req_s;
    logic                 sram_en_s;
    logic [IdxWidth-1:0]  sram_idx_s;
    logic [DataWidth-1:0] sram_rdata_s;
    logic [DataWidth-1:0] cl_reg_rdata_s;
    logic [DataWidth-1:0] host_reg_rdata_s;

    mem_rsp_t             rsp_r;
    logic                 rsp_valid_r;
    logic                 rsp_ram_rd_r;
    logic                 host_rvalid_r;
    logic                 host_ram_rd_r;
    logic [DataWidth-1:0] host_reg_rdata_r;
    logic [DataWidth-1:0] tohost_r;
    logic [DataWidth-1:0] fromhost_r;
    logic                 exit_valid_r;
    logic [31:0]          exit_code_r;

    assign cl_dec_s    = decode(req_addr_i);
    assign host_dec_s  = decode(host_addr_i);
    assign req_ready_o = !host_req_i;
    assign cl_fire_s   = req_valid_i && !host_req_i;

    // Single RAM port: host access first, otherwise an accepted cluster request.
    always_comb begin
        sram_req_s = '0;
        sram_en_s  = 1'b0;
        if (host_req_i) begin
            sram_en_s        = (host_dec_s == DEC_RAM);
            sram_req_s.addr  = host_addr_i;
            sram_req_s.we    = host_we_i;
            sram_req_s.wdata = host_wdata_i;
            sram_req_s.strb  = '1;
        end else if (cl_fire_s) begin
            sram_en_s        = (cl_dec_s == DEC_RAM);
            sram_req_s.addr  = req_addr_i;
            sram_req_s.we    = req_we_i;
            sram_req_s.wdata = req_wdata_i;
            sram_req_s.strb  = req_strb_i;
        end else begin
            sram_en_s = 1'b0;
        end
    end

    assign sram_idx_s = IdxWidth'((sram_req_s.addr - MemBase) >> OffBits);

    harness_sram #(
        .DataWidth (DataWidth),
        .Words     (MemWords)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (sram_en_s),
        .we_i    (sram_req_s.we),
        .idx_i   (sram_idx_s),
        .wdata_i (sram_req_s.wdata),
        .strb_i  (sram_req_s.strb),
        .rdata_o (sram_rdata_s)
    );

    // Mailbox register read values for both requesters.
    always_comb begin
        cl_reg_rdata_s   = '0;
        host_reg_rdata_s = '0;
        case (cl_dec_s)
            DEC_TOHOST:   cl_reg_rdata_s = tohost_r;
            DEC_FROMHOST: cl_reg_rdata_s = fromhost_r;
            default:      cl_reg_rdata_s = '0;
        endcase
        case (host_dec_s)
            DEC_TOHOST:   host_reg_rdata_s = tohost_r;
            DEC_FROMHOST: host_reg_rdata_s = fromhost_r;
            default:      host_reg_rdata_s = '0;
        endcase
    end

    // Response pipelines, mailbox registers and the sticky exit latch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_r            <= '0;
            rsp_valid_r      <= 1'b0;
            rsp_ram_rd_r     <= 1'b0;
            host_rvalid_r    <= 1'b0;
            host_ram_rd_r    <= 1'b0;
            host_reg_rdata_r <= '0;
            tohost_r         <= '0;
            fromhost_r       <= '0;
            exit_valid_r     <= 1'b0;
            exit_code_r      <= 32'd0;
        end else begin
            rsp_valid_r   <= cl_fire_s;
            rsp_r.err     <= cl_fire_s && (cl_dec_s == DEC_NONE);
            rsp_ram_rd_r  <= cl_fire_s && !req_we_i && (cl_dec_s == DEC_RAM);
            rsp_r.rdata   <= (cl_fire_s && !req_we_i) ? cl_reg_rdata_s : '0;

            host_rvalid_r    <= host_req_i;
            host_ram_rd_r    <= host_req_i && !host_we_i && (host_dec_s == DEC_RAM);
            host_reg_rdata_r <= (host_req_i && !host_we_i) ? host_reg_rdata_s : '0;

            if (host_req_i && host_we_i) begin
                case (host_dec_s)
                    DEC_TOHOST:   tohost_r   <= host_wdata_i;
                    DEC_FROMHOST: fromhost_r <= host_wdata_i;
                    default:      ;
                endcase
            end else if (cl_fire_s && req_we_i) begin
                case (cl_dec_s)
                    DEC_TOHOST:   tohost_r   <= merge_bytes(tohost_r, req_wdata_i, req_strb_i);
                    DEC_FROMHOST: fromhost_r <= merge_bytes(fromhost_r, req_wdata_i, req_strb_i);
                    default:      ;
                endcase
            end

            // Only the first exiting tohost write defines the exit code.
            if (cl_fire_s && req_we_i && (cl_dec_s == DEC_TOHOST) &&
                req_wdata_i[0] && !exit_valid_r) begin
                exit_valid_r <= 1'b1;
                exit_code_r  <= req_wdata_i[32:1];
            end
        end
    end

    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_err_o     = rsp_r.err;
    assign rsp_rdata_o   = rsp_ram_rd_r ? sram_rdata_s : rsp_r.rdata;
    assign host_rvalid_o = host_rvalid_r;
    assign host_rdata_o  = host_ram_rd_r ? sram_rdata_s : host_reg_rdata_r;
    assign exit_valid_o  = exit_valid_r;
    assign exit_code_o   = exit_code_r;

endmodule

// File: tb/tb_fesvr_harness_mem.sv
// Directed scoreboard bench for fesvr_harness_mem: expectations are queued
// when a request is driven and checked when the response pulse appears.
module tb_fesvr_harness_mem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_strb_i;
    logic        rsp_valid_o;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        host_req_i;
    logic        host_we_i;
    logic [31:0] host_addr_i;
    logic [63:0] host_wdata_i;
    logic        host_rvalid_o;
    logic [63:0] host_rdata_o;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;

    localparam logic [31:0] TOHOST   = 32'h0000_1000;
    localparam logic [31:0] FROMHOST = 32'h0000_1008;

    typedef struct {
        int          tag;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t cl_q[$];
    exp_t host_q[$];
    exp_t ce;
    exp_t he;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    fesvr_harness_mem dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_we_i      (req_we_i),
        .req_wdata_i   (req_wdata_i),
        .req_strb_i    (req_strb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .host_req_i    (host_req_i),
        .host_we_i     (host_we_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .exit_valid_o  (exit_valid_o),
        .exit_code_o   (exit_code_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cluster response scoreboard: a response must appear exactly one cycle after accept.
    always @(negedge clk_i) begin
        if (cl_q.size() > 0 && cl_q[0].tag + 1 <= cyc) begin
            ce = cl_q.pop_front();
            chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
            chk("rsp_rdata", rsp_rdata_o, ce.rdata);
            chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, ce.err});
        end else begin
            chk("rsp_idle", {63'd0, rsp_valid_o}, 64'd0);
        end
    end

    // Host response scoreboard.
    always @(negedge clk_i) begin
        if (host_q.size() > 0 && host_q[0].tag + 1 <= cyc) begin
            he = host_q.pop_front();
            chk("host_rvalid", {63'd0, host_rvalid_o}, 64'd1);
            chk("host_rdata", host_rdata_o, he.rdata);
        end else begin
            chk("host_idle", {63'd0, host_rvalid_o}, 64'd0);
        end
    end

    task automatic cl_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] strb, input logic push,
                          input logic [63:0] er, input logic ee);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_strb_i  = strb;
        if (push) cl_q.push_back('{cyc, er, ee});
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic host_acc(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                            input logic [63:0] er);
        @(negedge clk_i);
        host_req_i   = 1'b1;
        host_we_i    = we;
        host_addr_i  = addr;
        host_wdata_i = wdata;
        host_q.push_back('{cyc, er, 1'b0});
        @(posedge clk_i);
        #1 host_req_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = 32'd0;
        req_we_i     = 1'b0;
        req_wdata_i  = 64'd0;
        req_strb_i   = 8'd0;
        host_req_i   = 1'b0;
        host_we_i    = 1'b0;
        host_addr_i  = 32'd0;
        host_wdata_i = 64'd0;

        // Reset and idle
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_rsp_rdata", rsp_rdata_o, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err_o}, 64'd0);
        chk("rst_host_rdata", host_rdata_o, 64'd0);
        chk("rst_exit_code", {32'd0, exit_code_o}, 64'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            chk("idle_exit_valid", {63'd0, exit_valid_o}, 64'd0);
        end

        // Strobed RAM write and read-back
        host_acc(1'b1, 32'h8000_0010, 64'd0, 64'd0);
        cl_req(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, 64'd0, 1'b0);
        cl_req(1'b0, 32'h8000_0010, 64'd0, 8'h00, 1'b1, 64'h0000_0000_5566_7788, 1'b0);
        host_acc(1'b0, 32'h8000_0010, 64'd0, 64'h0000_0000_5566_7788);

        // RAM boundaries
        cl_req(1'b1, 32'h8000_7FF8, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1, 64'd0, 1'b0);
        cl_req(1'b0, 32'h8000_7FFC, 64'd0, 8'h00, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
        cl_req(1'b0, 32'h8000_8000, 64'd0, 8'h00, 1'b1, 64'd0, 1'b1);
        cl_req(1'b0, 32'h7FFF_FFF8, 64'd0, 8'h00, 1'b1, 64'd0, 1'b1);
        cl_req(1'b1, 32'h0000_2000, 64'h55, 8'hFF, 1'b1, 64'd0, 1'b1);

        // fromhost mailbox and unmapped read
        host_acc(1'b1, FROMHOST, 64'hABCD, 64'd0);
        cl_req(1'b0, FROMHOST, 64'd0, 8'h00, 1'b1, 64'hABCD, 1'b0);
        cl_req(1'b0, 32'h0000_100C, 64'd0, 8'h00, 1'b1, 64'hABCD, 1'b0);
        cl_req(1'b0, 32'h0000_2000, 64'd0, 8'h00, 1'b1, 64'd0, 1'b1);

        // Host and cluster collide for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            req_valid_i  = 1'b1;
            req_we_i     = 1'b0;
            req_addr_i   = 32'h8000_0010;
            host_req_i   = 1'b1;
            host_we_i    = 1'b0;
            host_addr_i  = FROMHOST;
            host_q.push_back('{cyc, 64'hABCD, 1'b0});
            #1 chk("arb_ready_low", {63'd0, req_ready_o}, 64'd0);
        end
        @(negedge clk_i);
        host_req_i = 1'b0;
        cl_q.push_back('{cyc, 64'h0000_0000_5566_7788, 1'b0});
        #1 chk("arb_ready_high", {63'd0, req_ready_o}, 64'd1);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;

        // tohost exit with code 0, then sticky behaviour
        cl_req(1'b1, TOHOST, 64'h1, 8'hFF, 1'b1, 64'd0, 1'b0);
        @(negedge clk_i);
        chk("exit_valid_set", {63'd0, exit_valid_o}, 64'd1);
        chk("exit_code_0", {32'd0, exit_code_o}, 64'd0);
        cl_req(1'b1, TOHOST, 64'hB, 8'hFF, 1'b1, 64'd0, 1'b0);
        cl_req(1'b0, TOHOST, 64'd0, 8'h00, 1'b1, 64'hB, 1'b0);
        @(negedge clk_i);
        chk("exit_code_sticky", {32'd0, exit_code_o}, 64'd0);
        host_acc(1'b1, TOHOST, 64'd0, 64'd0);
        cl_req(1'b0, TOHOST, 64'd0, 8'h00, 1'b1, 64'd0, 1'b0);
        @(negedge clk_i);
        chk("exit_valid_after_clear", {63'd0, exit_valid_o}, 64'd1);

        // Reset right after a read is accepted drops its response
        cl_req(1'b0, 32'h8000_0010, 64'd0, 8'h00, 1'b0, 64'd0, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_exit_valid", {63'd0, exit_valid_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("post_rst_exit_valid", {63'd0, exit_valid_o}, 64'd0);

        // Fresh exit with code 5
        cl_req(1'b1, TOHOST, 64'hB, 8'hFF, 1'b1, 64'd0, 1'b0);
        @(negedge clk_i);
        chk("exit_valid_b", {63'd0, exit_valid_o}, 64'd1);
        chk("exit_code_5", {32'd0, exit_code_o}, 64'd5);
        cl_req(1'b0, FROMHOST, 64'd0, 8'h00, 1'b1, 64'd0, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("cl_queue_drained", 64'(cl_q.size()), 64'd0);
        chk("host_queue_drained", 64'(host_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
